// File: rtl/vend_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vend_sequencer
// Purpose  : Vending machine transaction controller. Accepts coins and item
//            selections, holds the running credit, runs the dispense motor
//            and issues refunds/change. Phases are timed in whole seconds
//            from a one-cycle-per-second tick strobe.
// Ports    : clk, reset (async, active-low)
//            tick, coin_valid/coin_value, sel_valid/sel_price, cancel,
//            refund_ack                          -> inputs
//            credit, coin_reject, short_funds, motor_on,
//            refund_valid/refund_amt, state      -> registered outputs
// Revision : 1.0  initial release
// ============================================================================
module vend_sequencer #(
    parameter int CREDIT_W   = 8,
    parameter int TIMEOUT_S  = 10,
    parameter int DISPENSE_S = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                sel_valid,
    input  logic [CREDIT_W-1:0] sel_price,
    input  logic                cancel,
    input  logic                refund_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                short_funds,
    output logic                motor_on,
    output logic                refund_valid,
    output logic [CREDIT_W-1:0] refund_amt,
    output logic [1:0]          state
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COLLECT  = 2'd1;
    localparam logic [1:0] S_DISPENSE = 2'd2;
    localparam logic [1:0] S_REFUND   = 2'd3;

    localparam logic [7:0] C_TIMEOUT  = 8'(TIMEOUT_S);
    localparam logic [7:0] C_DISPENSE = 8'(DISPENSE_S);

    logic [1:0]          r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_change;
    logic [CREDIT_W-1:0] r_refund_amt;
    logic [7:0]          r_timer;
    logic                r_coin_reject;
    logic                r_short_funds;
    logic                r_motor_on;
    logic                r_refund_valid;

    // One extra bit so a credit overflow is visible as the carry out.
    logic [CREDIT_W:0]   w_sum;
    logic                w_overflow;
    logic                w_affordable;
    logic                w_expire;

    assign w_sum        = {1'b0, r_credit} + {1'b0, coin_value};
    assign w_overflow   = w_sum[CREDIT_W];
    assign w_affordable = (sel_price <= r_credit);
    assign w_expire     = tick && (r_timer == 8'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_change       <= '0;
            r_refund_amt   <= '0;
            r_timer        <= 8'd0;
            r_coin_reject  <= 1'b0;
            r_short_funds  <= 1'b0;
            r_motor_on     <= 1'b0;
            r_refund_valid <= 1'b0;
        end else begin
            // Pulse outputs default low so they are exactly one cycle wide.
            r_coin_reject <= 1'b0;
            r_short_funds <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (sel_valid) begin
                        // Credit is always zero while idle.
                        r_short_funds <= 1'b1;
                    end
                    if (coin_valid) begin
                        r_credit <= coin_value;
                        r_timer  <= C_TIMEOUT;
                        r_state  <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    if (cancel) begin
                        r_coin_reject <= coin_valid;
                        r_refund_amt  <= r_credit;
                        r_credit      <= '0;
                        r_state       <= S_REFUND;
                    end else if (sel_valid) begin
                        // A selection preempts any coin in the same cycle,
                        // and a failed selection freezes credit and timer.
                        r_coin_reject <= coin_valid;
                        if (w_affordable) begin
                            r_change   <= r_credit - sel_price;
                            r_credit   <= '0;
                            r_timer    <= C_DISPENSE;
                            r_motor_on <= 1'b1;
                            r_state    <= S_DISPENSE;
                        end else begin
                            r_short_funds <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        // A coin (accepted or rejected) absorbs any tick in
                        // the same cycle.
                        if (w_overflow) begin
                            r_coin_reject <= 1'b1;
                        end else begin
                            r_credit <= w_sum[CREDIT_W-1:0];
                            r_timer  <= C_TIMEOUT;
                        end
                    end else if (w_expire) begin
                        r_refund_amt <= r_credit;
                        r_credit     <= '0;
                        r_state      <= S_REFUND;
                    end else if (tick && (r_timer > 8'd1)) begin
                        r_timer <= r_timer - 8'd1;
                    end
                end

                S_DISPENSE: begin
                    r_coin_reject <= coin_valid;
                    if (w_expire) begin
                        r_motor_on <= 1'b0;
                        if (r_change != '0) begin
                            r_refund_amt <= r_change;
                            r_state      <= S_REFUND;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (tick && (r_timer > 8'd1)) begin
                        r_timer <= r_timer - 8'd1;
                    end
                end

                S_REFUND: begin
                    r_coin_reject <= coin_valid;
                    // refund_valid rises the cycle after entry; an ack is
                    // only honoured once the request is visible.
                    if (r_refund_valid && refund_ack) begin
                        r_refund_valid <= 1'b0;
                        r_change       <= '0;
                        r_state        <= S_IDLE;
                    end else begin
                        r_refund_valid <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign credit       = r_credit;
    assign coin_reject  = r_coin_reject;
    assign short_funds  = r_short_funds;
    assign motor_on     = r_motor_on;
    assign refund_valid = r_refund_valid;
    assign refund_amt   = r_refund_amt;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_vend_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_sequencer
// Purpose  : Directed self-checking bench for vend_sequencer with
//            hand-computed expected values.
// Revision : 1.0  initial release
// ============================================================================
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, coin_valid, sel_valid, cancel, refund_ack;
    logic [7:0] coin_value, sel_price;
    logic [7:0] credit, refund_amt;
    logic       coin_reject, short_funds, motor_on, refund_valid;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    vend_sequencer #(
        .CREDIT_W   (8),
        .TIMEOUT_S  (10),
        .DISPENSE_S (3)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .sel_valid    (sel_valid),
        .sel_price    (sel_price),
        .cancel       (cancel),
        .refund_ack   (refund_ack),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .short_funds  (short_funds),
        .motor_on     (motor_on),
        .refund_valid (refund_valid),
        .refund_amt   (refund_amt),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let one edge pass, then sample #1 later.
    task automatic step(input logic c, input logic [7:0] cv, input logic s,
                        input logic [7:0] sp, input logic cn, input logic tk,
                        input logic ak);
        coin_valid = c;  coin_value = cv;
        sel_valid  = s;  sel_price  = sp;
        cancel     = cn; tick       = tk;
        refund_ack = ak;
        @(posedge clk);
        #1;
        coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
        tick = 1'b0; refund_ack = 1'b0;
    endtask

    task automatic idle();
        step(0, 8'd0, 0, 8'd0, 0, 0, 0);
    endtask

    task automatic do_tick();
        step(0, 8'd0, 0, 8'd0, 0, 1, 0);
    endtask

    task automatic coin(input logic [7:0] v);
        step(1, v, 0, 8'd0, 0, 0, 0);
    endtask

    task automatic sel(input logic [7:0] p);
        step(0, 8'd0, 1, p, 0, 0, 0);
    endtask

    task automatic ack();
        step(0, 8'd0, 0, 8'd0, 0, 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        tick = 0; coin_valid = 0; sel_valid = 0; cancel = 0; refund_ack = 0;
        coin_value = 0; sel_price = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state",  state, 0);
        check("rst_credit", credit, 0);
        check("rst_motor",  motor_on, 0);
        check("rst_rv",     refund_valid, 0);
        check("rst_ramt",   refund_amt, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Tick ignored in IDLE, selection with no credit is short.
        do_tick();
        check("idle_tick_state", state, 0);
        sel(8'd7);
        check("idle_short", short_funds, 1);
        check("idle_short_state", state, 0);

        // Normal buy: 5 + 10, price 12, change 3.
        coin(8'd5);
        check("buy_state_c1", state, 1);
        check("buy_credit_5", credit, 5);
        coin(8'd10);
        check("buy_credit_15", credit, 15);
        sel(8'd12);
        check("buy_state_disp", state, 2);
        check("buy_motor_on", motor_on, 1);
        check("buy_credit_shown0", credit, 0);
        do_tick();
        check("buy_disp_t1", state, 2);
        coin(8'd1);
        check("buy_disp_reject", coin_reject, 1);
        do_tick();
        check("buy_reject_pulse_end", coin_reject, 0);
        check("buy_motor_t2", motor_on, 1);
        do_tick();
        check("buy_state_refund", state, 3);
        check("buy_motor_off", motor_on, 0);
        check("buy_rv_late", refund_valid, 0);
        step(1, 8'd2, 0, 8'd0, 0, 1, 0);
        check("buy_ref_reject", coin_reject, 1);
        check("buy_rv", refund_valid, 1);
        check("buy_ramt", refund_amt, 3);
        check("buy_ref_state", state, 3);
        ack();
        check("buy_ack_state", state, 0);
        check("buy_ack_rv", refund_valid, 0);
        check("buy_ack_credit", credit, 0);

        // Exact price: no refund after dispense.
        coin(8'd20);
        sel(8'd20);
        check("exact_disp", state, 2);
        do_tick(); do_tick(); do_tick();
        check("exact_idle", state, 0);
        check("exact_motor", motor_on, 0);
        check("exact_rv", refund_valid, 0);
        idle();
        check("exact_rv2", refund_valid, 0);

        // Short funds then timeout on the 10th tick.
        coin(8'd5);
        sel(8'd10);
        check("short_pulse", short_funds, 1);
        check("short_credit", credit, 5);
        check("short_state", state, 1);
        idle();
        check("short_pulse_end", short_funds, 0);
        for (int i = 0; i < 9; i++) do_tick();
        check("to_t9_state", state, 1);
        do_tick();
        check("to_t10_state", state, 3);
        check("to_ramt", refund_amt, 5);
        idle();
        check("to_rv", refund_valid, 1);
        ack();
        check("to_ack_state", state, 0);

        // Coin on tick 9 reloads the timer.
        coin(8'd5);
        for (int i = 0; i < 8; i++) do_tick();
        step(1, 8'd1, 0, 8'd0, 0, 1, 0);
        check("reload_credit", credit, 6);
        for (int i = 0; i < 9; i++) do_tick();
        check("reload_t9_state", state, 1);
        do_tick();
        check("reload_t10_state", state, 3);
        check("reload_ramt", refund_amt, 6);
        idle();
        ack();
        check("reload_ack_state", state, 0);

        // Overflow rejection, then cancel with simultaneous coin.
        coin(8'd200);
        coin(8'd50);
        check("ovf_credit_250", credit, 250);
        coin(8'd10);
        check("ovf_reject", coin_reject, 1);
        check("ovf_credit_kept", credit, 250);
        idle();
        check("ovf_reject_end", coin_reject, 0);
        step(1, 8'd1, 0, 8'd0, 1, 0, 0);
        check("cancel_reject", coin_reject, 1);
        check("cancel_state", state, 3);
        check("cancel_ramt", refund_amt, 250);
        idle();
        check("cancel_rv", refund_valid, 1);
        ack();
        check("cancel_ack_state", state, 0);

        // Asynchronous reset during dispense.
        coin(8'd20);
        sel(8'd5);
        check("ar_motor_pre", motor_on, 1);
        #2 reset = 1'b0;
        #1;
        check("ar_motor", motor_on, 0);
        check("ar_state", state, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("ar_state_after", state, 0);
        check("ar_credit_after", credit, 0);
        do_tick(); do_tick(); do_tick();
        check("ar_no_refund", refund_valid, 0);
        check("ar_idle_hold", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
